diff_accum: RTL and testbench
=============================

// Module: diff_accum
// PURPOSE
//  Downstream consumer of the sub block. Takes its WIDTH-bit difference (in1-in2, mod 2^WIDTH,
//  read as two's complement), accumulates a programmable-length frame of differences with a
//  valid/ready handshake, and emits one saturated signed frame sum per frame.
//  Sits between sub and any result sink (register file, capture logic, bench scoreboard).
// PARAMETERS
//  WIDTH      32   width of in_diff; must match the sub WIDTH
//  ACC_WIDTH  40   signed accumulator/out_sum width; ACC_WIDTH >= WIDTH+1
//  LEN_WIDTH  8    width of frame_len; max frame = 2^LEN_WIDTH-1 beats
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          start a frame; sampled only in IDLE
//  frame_len  in   LEN_WIDTH  beats per frame; latched on an accepted start
//  in_valid   in   1          in_diff valid
//  in_ready   out  1          block accepts a beat
//  in_diff    in   WIDTH      difference from sub, signed
//  out_valid  out  1          frame result valid
//  out_ready  in   1          sink accepts the result
//  out_sum    out  ACC_WIDTH  signed saturated frame sum
//  out_sat    out  1          saturation occurred during this frame
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; acc, count, len_q, out_sum=0; out_sat=0; out_valid=0;
//    in_ready=0; busy=0. Reset mid-frame drops the frame. No output after reset until a new start.
//  - States: IDLE, ACCUM, DONE.
//    IDLE:  in_ready=0. start=1 with frame_len!=0 -> latch len_q, acc=0, count=0, sat=0 -> ACCUM.
//           start=1 with frame_len==0 is ignored; stay IDLE.
//    ACCUM: in_ready=1. Beat = in_valid&&in_ready. Each beat: acc <= sat_add(acc, sext(in_diff)),
//           count <= count+1. Beat with count==len_q-1 -> DONE. No beat: hold.
//    DONE:  in_ready=0, out_valid=1, out_sum=acc, out_sat=sticky flag. Hold stable until
//           out_ready=1; then -> IDLE with out_valid=0 on the next cycle.
//  - Latency: out_valid rises in the cycle after the last beat is accepted. out_ready=1 already
//    high -> one DONE cycle. Best case: one frame per len_q+2 cycles.
//  - start in ACCUM or DONE is ignored; frame_len is only sampled on an accepted start.
//  - Arithmetic: in_diff is sign-extended to ACC_WIDTH. Positive overflow clamps to
//    2^(ACC_WIDTH-1)-1 and negative overflow clamps to -2^(ACC_WIDTH-1). Either one sets the sticky
//    sat flag for the frame. Accumulation continues from the clamped value.
//  - count is LEN_WIDTH bits and is never compared past len_q, so it cannot wrap.
//  - out_sum/out_sat keep the last result after leaving DONE, until the next start clears the flag.
//    out_sum changes only on DONE entry.
// STRUCTURE
//  - Package diff_accum_pkg: typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
//    functions or localparams for ACC_MAX/ACC_MIN derived from ACC_WIDTH.
//  - Sub-module sat_add: combinational signed saturating adder, #(W), ports a, b, sum, sat.
//  - Top: state register, len_q/count/acc registers, handshake decode. All flops use
//    async-reset-low.
// TESTING
//  1 Reset: rst_n=0 with arbitrary inputs -> all outputs 0 and state IDLE.
//    Release rst_n, no start -> in_ready stays 0.
//  2 Basic frame: start, frame_len=4; diffs 5,-3,10,-2 via sub (in1/in2 pairs), in_valid held ->
//    out_valid exactly 1 cycle after 4th beat, out_sum=10, out_sat=0.
//  3 Backpressure: frame_len=3 with in_valid gaps, then out_ready=0 for 5 cycles
//    -> out_valid and out_sum held stable, in_ready=0 in DONE. Release -> IDLE.
//  4 Saturation (ACC_WIDTH=33, WIDTH=32): frame_len=3, diffs 32'h7FFFFFFF x3 ->
//    out_sum=2^32-1, out_sat=1. Repeat with 32'h80000000 x3 -> out_sum=-2^32.
//  5 Edge starts: frame_len=0 start -> no busy. start during ACCUM -> ignored, frame completes.
//    frame_len=255 -> 255 beats accepted, then DONE.
//  6 Reset mid-frame: assert rst_n=0 after 2 of 4 beats -> immediate clear.
//    A new 2-beat frame of 1,1 then gives out_sum=2.

Source files
------------

// File: rtl/diff_accum_pkg.sv
// Shared types and saturation-limit helpers for the frame accumulator.
package diff_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widest accumulator the limit helpers can describe.
    localparam int unsigned MAX_ACC_WIDTH = 64;

    // Largest signed value of a w-bit word, zero-extended to MAX_ACC_WIDTH.
    function automatic logic [MAX_ACC_WIDTH-1:0] acc_max(input int unsigned w);
        logic [MAX_ACC_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_ACC_WIDTH; i++) begin
            if (i < w - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Smallest signed value of a w-bit word; the low w bits are 1 followed by zeros.
    function automatic logic [MAX_ACC_WIDTH-1:0] acc_min(input int unsigned w);
        logic [MAX_ACC_WIDTH-1:0] r;
        r = '1;
        for (int unsigned i = 0; i < MAX_ACC_WIDTH; i++) begin
            if (i < w - 1) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/diff_accum_sat_add.sv
// Combinational signed saturating adder.
module sat_add
    import diff_accum_pkg::*;
#(
    parameter int unsigned W = 40
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                sat
);

    localparam logic [W-1:0] MAX_V = W'(acc_max(W));
    localparam logic [W-1:0] MIN_V = W'(acc_min(W));

    logic [W:0] full;

    // One guard bit: overflow shows as disagreement between the top two bits.
    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        sat  = full[W] ^ full[W-1];
        if (!sat) begin
            sum = full[W-1:0];
        end else if (full[W]) begin
            sum = MIN_V;
        end else begin
            sum = MAX_V;
        end
    end

endmodule

// File: rtl/diff_accum.sv
// Frame accumulator: sums a programmable number of signed differences with
// saturation and hands one result per frame to a valid/ready sink.
module diff_accum
    import diff_accum_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_diff,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_sat,
    output logic                 busy
);

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic                   sat_q, sat_d;

    logic [ACC_WIDTH-1:0]   diff_ext;
    logic [ACC_WIDTH-1:0]   add_sum;
    logic                   add_sat;
    logic                   beat;
    logic                   last_beat;

    assign diff_ext  = {{(ACC_WIDTH - WIDTH){in_diff[WIDTH-1]}}, in_diff};
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_sat   = sat_q;
    assign beat      = in_valid && in_ready;
    // len_q is never zero in ACCUM, so len_q-1 cannot underflow here.
    assign last_beat = (count_q == len_q - LEN_WIDTH'(1));

    sat_add #(
        .W (ACC_WIDTH)
    ) u_sat_add (
        .a   (acc_q),
        .b   (diff_ext),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    len_d   = frame_len;
                    count_d = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d   = add_sum;
                    count_d = count_q + LEN_WIDTH'(1);
                    sat_d   = sat_q | add_sat;
                    if (last_beat) begin
                        sum_d   = add_sum;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_diff_accum.sv
// Directed bench for diff_accum: vector table of whole frames plus hand sequences
// for backpressure, ignored starts, the longest frame and reset mid-frame.
module tb_diff_accum;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ACC_WIDTH = 33;
    localparam int unsigned LEN_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [LEN_WIDTH-1:0] frame_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_diff;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_sat;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][31:0] in1;
        logic [3:0][31:0] in2;
        logic [32:0]      sum;
        logic             sat;
    } vec_t;

    vec_t vecs[5];

    diff_accum #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_diff   (in_diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] len, input logic [3:0][31:0] a,
                                input logic [3:0][31:0] b, input logic [32:0] s,
                                input logic sat);
        vec_t v;
        v.len = len;
        v.in1 = a;
        v.in2 = b;
        v.sum = s;
        v.sat = sat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full frame with in_valid held and out_ready high; checks latency and result.
    task automatic run_frame(input vec_t v, input string nm);
        start     = 1'b1;
        frame_len = v.len;
        step();
        start     = 1'b0;
        frame_len = '0;
        chk({nm, " in_ready in ACCUM"}, 64'(in_ready), 64'd1);
        for (int i = 0; i < int'(v.len); i++) begin
            in_valid = 1'b1;
            in_diff  = v.in1[i] - v.in2[i];
            if (i == int'(v.len) - 1) chk({nm, " no early out_valid"}, 64'(out_valid), 64'd0);
            step();
        end
        in_valid = 1'b0;
        chk({nm, " out_valid"}, 64'(out_valid), 64'd1);
        chk({nm, " out_sum"}, 64'(out_sum), 64'(v.sum));
        chk({nm, " out_sat"}, 64'(out_sat), 64'(v.sat));
        chk({nm, " in_ready in DONE"}, 64'(in_ready), 64'd0);
        step();
        chk({nm, " back to idle"}, 64'({out_valid, busy}), 64'd0);
    endtask

    initial begin
        logic pat[6];
        int   k;

        vecs[0] = mk(8'd4, {32'd0, 32'd20, 32'd4, 32'd12}, {32'd2, 32'd10, 32'd7, 32'd7},
                     33'd10, 1'b0);
        vecs[1] = mk(8'd3, {4{32'h7fff_ffff}}, '0, 33'h0_ffff_ffff, 1'b1);
        vecs[2] = mk(8'd3, '0, {4{32'h8000_0000}}, 33'h1_0000_0000, 1'b1);
        vecs[3] = mk(8'd1, {96'd0, 32'd3}, {96'd0, 32'd4}, 33'h1_ffff_ffff, 1'b0);
        vecs[4] = mk(8'd2, {64'd0, 32'h0, 32'h7fff_ffff}, {64'd0, 32'h8000_0000, 32'h0},
                     33'h1_ffff_ffff, 1'b0);

        // Reset with arbitrary inputs driven.
        rst_n     = 1'b0;
        start     = 1'b1;
        frame_len = 8'd9;
        in_valid  = 1'b1;
        in_diff   = 32'hdead_beef;
        out_ready = 1'b0;
        #3;
        chk("reset outputs", 64'({in_ready, out_valid, out_sat, busy}), 64'd0);
        chk("reset out_sum", 64'(out_sum), 64'd0);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle after reset", 64'({in_ready, busy}), 64'd0);
        end

        // Table of whole frames.
        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: gaps on input, sink stalls for 5 cycles.
        out_ready = 1'b0;
        start     = 1'b1;
        frame_len = 8'd3;
        step();
        start = 1'b0;
        pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        k     = 0;
        for (int j = 0; j < 6; j++) begin
            in_valid = pat[j];
            in_diff  = pat[j] ? 32'(k + 1) : 32'hffff_ffff;
            if (pat[j]) k++;
            if (j == 5) chk("bp no early out_valid", 64'({out_valid, busy}), 64'd1);
            step();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("bp hold out_valid", 64'(out_valid), 64'd1);
            chk("bp hold out_sum", 64'(out_sum), 64'd6);
            chk("bp in_ready low", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp release idle", 64'({out_valid, busy}), 64'd0);
        chk("bp sum kept", 64'(out_sum), 64'd6);

        // Zero-length start is ignored.
        start     = 1'b1;
        frame_len = 8'd0;
        step();
        start = 1'b0;
        chk("len0 ignored", 64'({in_ready, busy}), 64'd0);

        // Start during ACCUM is ignored; the 2-beat frame still completes.
        start     = 1'b1;
        frame_len = 8'd2;
        step();
        in_valid  = 1'b1;
        in_diff   = 32'd4;
        start     = 1'b1;
        frame_len = 8'd5;
        step();
        start     = 1'b0;
        frame_len = '0;
        in_diff   = 32'd6;
        step();
        in_valid = 1'b0;
        chk("restart ignored out_valid", 64'(out_valid), 64'd1);
        chk("restart ignored out_sum", 64'(out_sum), 64'd10);
        step();
        chk("restart ignored idle", 64'(busy), 64'd0);

        // Longest frame: 255 beats.
        start     = 1'b1;
        frame_len = 8'd255;
        step();
        start = 1'b0;
        for (int i = 0; i < 255; i++) begin
            in_valid = 1'b1;
            in_diff  = 32'd1;
            if (i == 254) chk("len255 still accum", 64'({out_valid, in_ready}), 64'd1);
            step();
        end
        in_valid = 1'b0;
        chk("len255 out_valid", 64'(out_valid), 64'd1);
        chk("len255 out_sum", 64'(out_sum), 64'd255);
        chk("len255 out_sat", 64'(out_sat), 64'd0);
        step();

        // Reset after 2 of 4 beats clears everything immediately.
        start     = 1'b1;
        frame_len = 8'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_diff  = 32'd7;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", 64'({in_ready, out_valid, out_sat, busy}), 64'd0);
        chk("midreset out_sum", 64'(out_sum), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("midreset stays idle", 64'({out_valid, busy}), 64'd0);
        run_frame(mk(8'd2, {64'd0, 32'd1, 32'd1}, '0, 33'd2, 1'b0), "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
